// File: rtl/csa_pipe_adder.sv
`timescale 1ns/1ps
// csa_pipe_adder: carry-skip adder pipelined one BLK-bit block per stage, valid/ready on both sides.
// Define CSA_PIPE_OVF_EN to add the registered two's-complement overflow output ovf.
module csa_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic [15:0]      skip_cnt
`ifdef CSA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = WIDTH / BLK;
  localparam int LAST = NBLK - 1;

  logic             r_v [NBLK];
  logic [WIDTH-1:0] r_a [NBLK];
  logic [WIDTH-1:0] r_b [NBLK];
  logic [WIDTH-1:0] r_s [NBLK];
  logic             r_c [NBLK];
  logic [15:0]      r_skip_cnt;

  logic             w_adv;
  logic             w_vi [NBLK];
  logic             w_ci [NBLK];
  logic [WIDTH-1:0] w_ai [NBLK];
  logic [WIDTH-1:0] w_bi [NBLK];
  logic [WIDTH-1:0] w_si [NBLK];
  logic [BLK-1:0]   w_blk_sum [NBLK];
  logic             w_co [NBLK];
  logic             w_skip [NBLK];
  logic [16:0]      w_skip_inc;
  logic [16:0]      w_skip_sum;

  // Every stage moves in lockstep, so one advance condition gates the whole pipe.
  assign w_adv     = !r_v[LAST] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v[LAST];
  assign s         = r_s[LAST];
  assign c_out     = r_c[LAST];
  assign skip_cnt  = r_skip_cnt;

  generate
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_stage
      logic [BLK-1:0] w_as;
      logic [BLK-1:0] w_bs;
      logic           w_rc;

      if (gi == 0) begin : g_head
        assign w_vi[gi] = in_valid;
        assign w_ai[gi] = a;
        assign w_bi[gi] = b;
        assign w_ci[gi] = c_in;
        assign w_si[gi] = '0;
      end else begin : g_body
        assign w_vi[gi] = r_v[gi-1];
        assign w_ai[gi] = r_a[gi-1];
        assign w_bi[gi] = r_b[gi-1];
        assign w_ci[gi] = r_c[gi-1];
        assign w_si[gi] = r_s[gi-1];
      end

      assign w_as = w_ai[gi][gi*BLK +: BLK];
      assign w_bs = w_bi[gi][gi*BLK +: BLK];
      assign {w_rc, w_blk_sum[gi]} = {1'b0, w_as} + {1'b0, w_bs} + {{BLK{1'b0}}, w_ci[gi]};
      // A fully propagating block passes its carry-in straight through.
      assign w_skip[gi] = &(w_as ^ w_bs);
      assign w_co[gi]   = w_skip[gi] ? w_ci[gi] : w_rc;
    end
  endgenerate

  always_comb begin
    w_skip_inc = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (w_vi[k] && w_skip[k]) begin
        w_skip_inc = w_skip_inc + 17'd1;
      end
    end
    w_skip_sum = {1'b0, r_skip_cnt} + w_skip_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NBLK; k++) begin
        r_v[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
      end
      r_skip_cnt <= '0;
`ifdef CSA_PIPE_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (w_adv) begin
      for (int k = 0; k < NBLK; k++) begin
        r_v[k] <= w_vi[k];
        r_a[k] <= w_ai[k];
        r_b[k] <= w_bi[k];
        r_c[k] <= w_co[k];
        r_s[k] <= w_si[k];
        r_s[k][k*BLK +: BLK] <= w_blk_sum[k];
      end
      r_skip_cnt <= w_skip_sum[16] ? 16'hFFFF : w_skip_sum[15:0];
`ifdef CSA_PIPE_OVF_EN
      ovf <= (w_ai[LAST][WIDTH-1] == w_bi[LAST][WIDTH-1]) &&
             (w_blk_sum[LAST][BLK-1] != w_ai[LAST][WIDTH-1]);
`endif
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
`timescale 1ns/1ps
// tb_csa_pipe_adder: directed vector table, random scoreboard traffic, stall, saturation and reset cases.
module tb_csa_pipe_adder;
  localparam int WIDTH = 16;
  localparam int BLK   = 4;
  localparam int NBLK  = WIDTH / BLK;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        c_out;
  logic [15:0] skip_cnt;
`ifdef CSA_PIPE_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  csa_pipe_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .skip_cnt  (skip_cnt)
`ifdef CSA_PIPE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    int          skips;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_skip = 0;
  logic [16:0] sb_q[$];
  bit          hold_prev = 1'b0;
  logic [16:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int ref_skips(input logic [15:0] x, input logic [15:0] y);
    int n = 0;
    int p = int'(x ^ y);
    for (int i = 0; i < NBLK; i++) begin
      if (((p >> (i * BLK)) % (1 << BLK)) == (1 << BLK) - 1) n++;
    end
    return n;
  endfunction

  function automatic logic [16:0] ref_sum(input logic [15:0] x, input logic [15:0] y, input logic ci);
    return 17'(int'(x) + int'(y) + int'(ci));
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input vec_t v, input int idx);
    int lat;
    out_ready = 1'b1;
    a = v.a; b = v.b; c_in = v.ci; in_valid = 1'b1;
    #1;
    chk("vec_in_ready", 32'(in_ready), 32'd1);
    exp_skip += v.skips;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("vec_latency", 32'(lat), 32'(NBLK));
    chk("vec_sum", 32'({c_out, s}), 32'({v.co, v.s}));
    chk("vec_skip_cnt", 32'(skip_cnt), 32'(sat(exp_skip)));
    $display("vec %0d: a=%h b=%h ci=%b -> s=%h c_out=%b skip_cnt=%0d latency=%0d",
             idx, v.a, v.b, v.ci, s, c_out, skip_cnt, lat);
    tick();
    chk("vec_drained", 32'(out_valid), 32'd0);
  endtask

  task automatic sb_cycle(input bit iv, input bit orr, input logic [15:0] ta,
                          input logic [15:0] tb_, input logic tc, output bit fired);
    logic        exp_rdy;
    logic [16:0] exp;
    a = ta; b = tb_; c_in = tc; in_valid = iv; out_ready = orr;
    #1;
    exp_rdy = !out_valid || orr;
    chk("sb_in_ready", 32'(in_ready), 32'(exp_rdy));
    if (hold_prev) chk("sb_hold", 32'({out_valid, c_out, s}), 32'({1'b1, held}));
    fired = out_valid && orr;
    if (fired) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        exp = sb_q.pop_front();
        chk("sb_result", 32'({c_out, s}), 32'(exp));
        $display("sb: s=%h c_out=%b expected %h", s, c_out, exp);
      end
    end
    hold_prev = out_valid && !orr;
    held = {c_out, s};
    if (iv && exp_rdy) begin
      sb_q.push_back(ref_sum(ta, tb_, tc));
      exp_skip += ref_skips(ta, tb_);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit f;
    for (int i = 0; i < 40 && (sb_q.size() != 0 || out_valid); i++) begin
      sb_cycle(1'b0, 1'b1, 16'h0, 16'h0, 1'b0, f);
    end
    chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_skip_cnt", 32'(skip_cnt), 32'(sat(exp_skip)));
  endtask

`ifdef CSA_PIPE_OVF_EN
  task automatic ovf_case(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] es,
                          input logic eo);
    int lat;
    out_ready = 1'b1;
    a = ta; b = tb_; c_in = 1'b0; in_valid = 1'b1;
    exp_skip += ref_skips(ta, tb_);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("ovf_sum", 32'(s), 32'(es));
    chk("ovf_flag", 32'(ovf), 32'(eo));
    $display("ovf: a=%h b=%h -> s=%h ovf=%b", ta, tb_, s, ovf);
    tick();
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    bit   f;
    int   cnt, first, last;

    vecs[0] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4};
    vecs[1] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0};
    vecs[4] = '{16'h00F0, 16'hFF0F, 1'b0, 16'hFFFF, 1'b0, 4};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0};
    vecs[6] = '{16'h0F0F, 16'h0000, 1'b1, 16'h0F10, 1'b0, 2};
    vecs[7] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 2};

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_s", 32'(s), 32'd0);
    chk("reset_c_out", 32'(c_out), 32'd0);
    chk("reset_skip_cnt", 32'(skip_cnt), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    #20 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_one(vecs[i], i);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      sb_cycle(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60),
               16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), f);
    end
    drain();

    // Back-to-back: 8 results on consecutive cycles.
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 20; i++) begin
      sb_cycle(i < 8, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), f);
      if (f) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
    end
    chk("b2b_count", 32'(cnt), 32'd8);
    chk("b2b_consecutive", 32'(last - first), 32'd7);
    drain();

    // Stall: results pending with out_ready low for several cycles.
    for (int i = 0; i < 3; i++)
      sb_cycle(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), f);
    for (int i = 0; i < 6; i++)
      sb_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, f);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    drain();

    // Saturation of skip_cnt.
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0000; c_in = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16400; i++) @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_skip += 16400 * 4;
    for (int i = 0; i < 8; i++) tick();
    chk("sat_skip_cnt", 32'(skip_cnt), 32'(sat(exp_skip)));
    chk("sat_out_valid", 32'(out_valid), 32'd0);
    $display("saturation: skip_cnt=%h", skip_cnt);

    // Reset while one result is held at the output and another is mid-pipe.
    sb_cycle(1'b1, 1'b0, 16'h1234, 16'h4321, 1'b0, f);
    sb_cycle(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, f);
    sb_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, f);
    sb_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, f);
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    chk("rst_pre_sum", 32'({c_out, s}), 32'(ref_sum(16'h1234, 16'h4321, 1'b0)));
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", 32'(out_valid), 32'd0);
    chk("rst_async_s", 32'(s), 32'd0);
    chk("rst_async_c_out", 32'(c_out), 32'd0);
    chk("rst_async_skip_cnt", 32'(skip_cnt), 32'd0);
    chk("rst_async_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    exp_skip = 0;
    hold_prev = 1'b0;
    tick();
    chk("rst_hold_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) cnt++;
      tick();
    end
    chk("rst_no_ghost_results", 32'(cnt), 32'd0);
    $display("reset: in-flight results discarded, ghost outputs=%0d", cnt);

    run_one(vecs[0], 8);

`ifdef CSA_PIPE_OVF_EN
    ovf_case(16'h7FFF, 16'h0001, 16'h8000, 1'b1);
    ovf_case(16'h8000, 16'h8000, 16'h0000, 1'b1);
    ovf_case(16'h0001, 16'h0001, 16'h0002, 1'b0);
    ovf_case(16'hFFFF, 16'h0001, 16'h0000, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csa_pipe_adder.md
CSA_PIPE_ADDER -- requirements
Module: csa_pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits.
REQ-002 The block SHALL have parameter BLK, default 4, meaning skip-block width in bits; WIDTH SHALL be an integer multiple of BLK, and NBLK = WIDTH/BLK.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operands valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: operands accepted this cycle when in_valid is also 1.
REQ-008 The block SHALL have port a, input, WIDTH bits: addend.
REQ-009 The block SHALL have port b, input, WIDTH bits: addend.
REQ-010 The block SHALL have port c_in, input, 1 bit: carry in.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 The block SHALL have port s, output, WIDTH bits: sum.
REQ-014 The block SHALL have port c_out, output, 1 bit: carry out.
REQ-015 The block SHALL have port skip_cnt, output, 16 bits: saturating count of block carries resolved through the skip path.

Function
REQ-016 Pipeline stage k (k = 0..NBLK-1) SHALL compute bits [k*BLK +: BLK] from registered operand slices and the registered carry of stage k-1; stage 0 SHALL use c_in.
REQ-017 Each stage carry-out SHALL equal the stage carry-in when all BLK propagate bits (a^b) are 1, and otherwise SHALL equal the ripple carry of that block.
REQ-018 Operand slices for blocks not yet processed, and sum slices already produced, SHALL be carried forward in skew and deskew registers so that one transaction exits with the full s word.
REQ-019 Latency SHALL be exactly NBLK cycles from an accepted input to out_valid, with no stall; throughput SHALL be one transaction per cycle.
REQ-020 {c_out, s} SHALL equal a + b + c_in, computed modulo 2^(WIDTH+1).
REQ-021 The pipeline SHALL advance when (!out_valid || out_ready), and SHALL freeze all stage registers otherwise.
REQ-022 in_ready SHALL equal the advance condition.
REQ-023 Each stage SHALL carry a valid bit, so bubbles propagate and are never presented as results.
REQ-024 s, c_out and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-025 skip_cnt SHALL increment by the number of valid stages that advance this cycle and take the skip path.
REQ-026 skip_cnt SHALL saturate at 16'hFFFF and SHALL never wrap.
REQ-027 A simultaneous input accept and output accept SHALL both complete in the same cycle.

Reset
REQ-028 While rst_n is 0, all stage valid bits SHALL be cleared, and out_valid, s, c_out and skip_cnt SHALL be 0, immediately and without waiting for a clock edge.
REQ-029 A reset assertion mid-operation SHALL discard all in-flight transactions; none SHALL emerge after reset release.
REQ-030 in_ready SHALL be 1 during and after reset.

Configuration
REQ-031 When macro CSA_PIPE_OVF_EN is defined, the block SHALL have an extra output ovf, 1 bit, pipelined alongside s.
REQ-032 With CSA_PIPE_OVF_EN defined, ovf SHALL be 1 when the two's-complement addition overflows, i.e. a[MSB]==b[MSB] and s[MSB]!=a[MSB]; ovf SHALL reset to 0.
REQ-033 Without CSA_PIPE_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=16, BLK=4)
REQ-034 Scenario: a=16'hFFFF, b=16'h0000, c_in=1, accepted at cycle 0 -> out_valid at cycle 4 with s=16'h0000, c_out=1, and skip_cnt=4.
REQ-035 Scenario: a=16'h1234, b=16'h4321, c_in=0 -> s=16'h5555, c_out=0, and skip_cnt unchanged.
REQ-036 Scenario: 8 back-to-back inputs with out_ready=1 -> 8 results on consecutive cycles, in order, all matching the reference sum.
REQ-037 Scenario: out_ready=0 for 5 cycles with results pending -> in_ready=0, and s and c_out hold; after release, no transaction is lost or duplicated.
REQ-038 Scenario: rst_n pulsed low at cycle 2 of an in-flight transaction -> outputs 0 asynchronously, and no result appears for that transaction.
REQ-039 Scenario: CSA_PIPE_OVF_EN defined, a=16'h7FFF, b=16'h0001, c_in=0 -> s=16'h8000 and ovf=1.
